// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary register with valid/ready handshake and an optional
// 2-entry skid buffer. Flush injects a bubble and a saturating counter tracks effective flushes.
module if_id_skid #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              PC_STEP   = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = '0,
  parameter bit              SKID      = 1'b1,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [ILEN-1:0]  in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ILEN-1:0]  out_instr_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [XLEN-1:0]  out_pc_next_o,
  output logic             out_noflush_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic             mainValid_q, mainValid_d;
  logic [ILEN-1:0]  mainInstr_q, mainInstr_d;
  logic [XLEN-1:0]  mainPc_q, mainPc_d;
  logic [XLEN-1:0]  mainPcNext_q, mainPcNext_d;
  logic             skidValid_q, skidValid_d;
  logic [ILEN-1:0]  skidInstr_q, skidInstr_d;
  logic [XLEN-1:0]  skidPc_q, skidPc_d;
  logic [XLEN-1:0]  skidPcNext_q, skidPcNext_d;
  logic             inReady_q, inReady_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic             inXfer;
  logic             drain;
  logic [XLEN-1:0]  inPcNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainValid_q  <= 1'b0;
      mainInstr_q  <= NOP_INSTR;
      mainPc_q     <= '0;
      mainPcNext_q <= '0;
      skidValid_q  <= 1'b0;
      skidInstr_q  <= NOP_INSTR;
      skidPc_q     <= '0;
      skidPcNext_q <= '0;
      inReady_q    <= 1'b1;
      flushCnt_q   <= '0;
    end else begin
      mainValid_q  <= mainValid_d;
      mainInstr_q  <= mainInstr_d;
      mainPc_q     <= mainPc_d;
      mainPcNext_q <= mainPcNext_d;
      skidValid_q  <= skidValid_d;
      skidInstr_q  <= skidInstr_d;
      skidPc_q     <= skidPc_d;
      skidPcNext_q <= skidPcNext_d;
      inReady_q    <= inReady_d;
      flushCnt_q   <= flushCnt_d;
    end
  end

  assign inXfer   = in_valid_i & in_ready_o;
  assign drain    = ~mainValid_q | out_ready_i;
  assign inPcNext = in_pc_i + XLEN'(PC_STEP);

  always_comb begin
    mainValid_d  = mainValid_q;
    mainInstr_d  = mainInstr_q;
    mainPc_d     = mainPc_q;
    mainPcNext_d = mainPcNext_q;
    skidValid_d  = skidValid_q;
    skidInstr_d  = skidInstr_q;
    skidPc_d     = skidPc_q;
    skidPcNext_d = skidPcNext_q;
    flushCnt_d   = flushCnt_q;

    if (flush_i) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
      if ((mainValid_q | skidValid_q | inXfer) && (flushCnt_q != '1))
        flushCnt_d = flushCnt_q + CNT_W'(1);
    end else if (drain) begin
      // The skid entry is older than anything on the input, so it wins the main slot
      if (skidValid_q) begin
        mainValid_d  = 1'b1;
        mainInstr_d  = skidInstr_q;
        mainPc_d     = skidPc_q;
        mainPcNext_d = skidPcNext_q;
        skidValid_d  = 1'b0;
      end else begin
        mainValid_d = inXfer;
        if (inXfer) begin
          mainInstr_d  = in_instr_i;
          mainPc_d     = in_pc_i;
          mainPcNext_d = inPcNext;
        end
      end
    end else if (inXfer && SKID) begin
      skidValid_d  = 1'b1;
      skidInstr_d  = in_instr_i;
      skidPc_d     = in_pc_i;
      skidPcNext_d = inPcNext;
    end

    inReady_d = ~skidValid_d;
  end

  assign in_ready_o    = SKID ? inReady_q : (~mainValid_q | out_ready_i);
  assign out_valid_o   = mainValid_q;
  assign out_noflush_o = mainValid_q;
  assign out_instr_o   = mainValid_q ? mainInstr_q  : NOP_INSTR;
  assign out_pc_o      = mainValid_q ? mainPc_q     : '0;
  assign out_pc_next_o = mainValid_q ? mainPcNext_q : '0;
  assign flush_cnt_o   = flushCnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: a SKID=1 build with a 2-bit flush counter
// and a SKID=0 build sharing the same input stimulus.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, flush, outReady;
  logic [31:0] inInstr, inPc;

  logic        inReady1, outValid1, outNoflush1;
  logic [31:0] outInstr1, outPc1, outPcNext1;
  logic [1:0]  flushCnt1;

  logic        inReady0, outValid0, outNoflush0;
  logic [31:0] outInstr0, outPc0, outPcNext0;
  logic [15:0] flushCnt0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_skid #(.NOP_INSTR(NOP), .SKID(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid_i(inValid), .in_ready_o(inReady1),
    .in_instr_i(inInstr), .in_pc_i(inPc), .flush_i(flush),
    .out_valid_o(outValid1), .out_ready_i(outReady), .out_instr_o(outInstr1),
    .out_pc_o(outPc1), .out_pc_next_o(outPcNext1), .out_noflush_o(outNoflush1),
    .flush_cnt_o(flushCnt1)
  );

  if_id_skid #(.NOP_INSTR(NOP), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid_i(inValid), .in_ready_o(inReady0),
    .in_instr_i(inInstr), .in_pc_i(inPc), .flush_i(flush),
    .out_valid_o(outValid0), .out_ready_i(outReady), .out_instr_o(outInstr0),
    .out_pc_o(outPc0), .out_pc_next_o(outPcNext0), .out_noflush_o(outNoflush0),
    .flush_cnt_o(flushCnt0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] epcn;
    logic        eir;
    logic [1:0]  ecnt;
    logic        chk0;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {pc[15:0], 16'hBEEF};
  endfunction

  task automatic addVec(input logic iv, input logic [31:0] pc, input logic ordy,
                        input logic fl, input logic eov, input logic [31:0] epc,
                        input logic [31:0] epcn, input logic eir,
                        input logic [1:0] ecnt, input logic chk0);
    vec_t v;
    v = '{iv, pc, ordy, fl, eov, epc, epcn, eir, ecnt, chk0};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s idx=%0d actual=%h expected=%h", name, idx, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    inValid  = v.iv;
    inPc     = v.pc;
    inInstr  = instrOf(v.pc);
    outReady = v.ordy;
    flush    = v.fl;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    inValid  = 1'b0;
    inPc     = '0;
    inInstr  = '0;
    outReady = 1'b0;
    flush    = 1'b0;

    // reset values, observed while reset is still held
    #1;
    checkOutput("rst_valid",   0, {31'b0, outValid1},   32'd0);
    checkOutput("rst_noflush", 0, {31'b0, outNoflush1}, 32'd0);
    checkOutput("rst_instr",   0, outInstr1,            NOP);
    checkOutput("rst_pc",      0, outPc1,               32'd0);
    checkOutput("rst_pcn",     0, outPcNext1,           32'd0);
    checkOutput("rst_cnt",     0, {30'b0, flushCnt1},   32'd0);
    checkOutput("rst_cnt0",    0, {16'b0, flushCnt0},   32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_inready1", 0, {31'b0, inReady1}, 32'd1);
    checkOutput("rst_inready0", 0, {31'b0, inReady0}, 32'd1);

    //      iv  pc            ordy fl  eov epc           epcn          eir cnt chk0
    addVec(1, 32'h100,        1,   0,  1,  32'h100,      32'h104,      1,  0,  1);
    addVec(1, 32'h104,        1,   0,  1,  32'h104,      32'h108,      1,  0,  1);
    addVec(1, 32'h108,        1,   0,  1,  32'h108,      32'h10C,      1,  0,  1);
    addVec(0, 32'h0,          1,   0,  0,  32'h0,        32'h0,        1,  0,  1);
    addVec(1, 32'h200,        0,   0,  1,  32'h200,      32'h204,      1,  0,  0);
    addVec(1, 32'h204,        0,   0,  1,  32'h200,      32'h204,      0,  0,  0);
    addVec(1, 32'h208,        0,   0,  1,  32'h200,      32'h204,      0,  0,  0);
    addVec(0, 32'h0,          1,   0,  1,  32'h204,      32'h208,      1,  0,  0);
    addVec(0, 32'h0,          1,   0,  0,  32'h0,        32'h0,        1,  0,  0);
    addVec(1, 32'hFFFF_FFFC,  1,   0,  1,  32'hFFFF_FFFC, 32'h0,       1,  0,  0);
    addVec(0, 32'h0,          1,   0,  0,  32'h0,        32'h0,        1,  0,  0);
    addVec(1, 32'h300,        0,   0,  1,  32'h300,      32'h304,      1,  0,  0);
    addVec(1, 32'h304,        0,   0,  1,  32'h300,      32'h304,      0,  0,  0);
    addVec(1, 32'h308,        0,   1,  0,  32'h0,        32'h0,        1,  1,  0);
    addVec(0, 32'h0,          1,   0,  0,  32'h0,        32'h0,        1,  1,  0);
    addVec(0, 32'h0,          1,   1,  0,  32'h0,        32'h0,        1,  1,  0);
    addVec(1, 32'h400,        1,   1,  0,  32'h0,        32'h0,        1,  2,  0);
    addVec(1, 32'h500,        0,   0,  1,  32'h500,      32'h504,      1,  2,  0);
    addVec(0, 32'h0,          0,   1,  0,  32'h0,        32'h0,        1,  3,  0);
    addVec(1, 32'h600,        0,   0,  1,  32'h600,      32'h604,      1,  3,  0);
    addVec(0, 32'h0,          0,   1,  0,  32'h0,        32'h0,        1,  3,  0);
    addVec(1, 32'h700,        1,   1,  0,  32'h0,        32'h0,        1,  3,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] expInstr;
      applyStimulus(vecs[i]);
      expInstr = vecs[i].eov ? instrOf(vecs[i].epc) : NOP;
      checkOutput("out_valid",   i, {31'b0, outValid1},   {31'b0, vecs[i].eov});
      checkOutput("out_noflush", i, {31'b0, outNoflush1}, {31'b0, vecs[i].eov});
      checkOutput("out_instr",   i, outInstr1,            expInstr);
      checkOutput("out_pc",      i, outPc1,               vecs[i].epc);
      checkOutput("out_pc_next", i, outPcNext1,           vecs[i].epcn);
      checkOutput("in_ready",    i, {31'b0, inReady1},    {31'b0, vecs[i].eir});
      checkOutput("flush_cnt",   i, {30'b0, flushCnt1},   {30'b0, vecs[i].ecnt});
      if (vecs[i].chk0) begin
        checkOutput("s0_out_valid", i, {31'b0, outValid0}, {31'b0, vecs[i].eov});
        checkOutput("s0_out_instr", i, outInstr0,          expInstr);
        checkOutput("s0_out_pc",    i, outPc0,             vecs[i].epc);
        checkOutput("s0_out_pcn",   i, outPcNext0,         vecs[i].epcn);
        checkOutput("s0_in_ready",  i, {31'b0, inReady0},  32'd1);
      end
    end

    // asynchronous reset while holding an entry, checked well before the next edge
    inValid  = 1'b1;
    inPc     = 32'h800;
    inInstr  = instrOf(32'h800);
    outReady = 1'b0;
    flush    = 1'b0;
    tick();
    inValid = 1'b0;
    checkOutput("pre_areset_valid", 0, {31'b0, outValid1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_valid", 0, {31'b0, outValid1}, 32'd0);
    checkOutput("areset_instr", 0, outInstr1,          NOP);
    checkOutput("areset_pc",    0, outPc1,             32'd0);
    checkOutput("areset_cnt",   0, {30'b0, flushCnt1}, 32'd0);
    #2 reset = 1'b0;

    // SKID=0: in_ready follows out_ready combinationally while main is full
    inValid  = 1'b1;
    inPc     = 32'h900;
    inInstr  = instrOf(32'h900);
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    checkOutput("s0_load_valid", 0, {31'b0, outValid0}, 32'd1);
    checkOutput("s0_load_pc",    0, outPc0,             32'h900);
    outReady = 1'b0;
    #1;
    checkOutput("s0_comb_ready_lo", 0, {31'b0, inReady0}, 32'd0);
    outReady = 1'b1;
    #1;
    checkOutput("s0_comb_ready_hi", 0, {31'b0, inReady0}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline boundary register with a valid/ready handshake and an optional 2-entry skid buffer.
- The fetch stage can stall without a combinational ready path back from decode.
- Carries instr, pc and precomputed pc_next, and injects a NOP bubble on flush.
- Sits between the fetch unit and the decoder in the mini CPU. Includes a saturating flush-event counter for performance monitoring.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- PC_STEP, 4, increment added to in_pc to form pc_next.
- NOP_INSTR, 32'h0000_0000, instr value presented while the stage is empty or flushed. Width ILEN.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with pass-through ready.
- CNT_W, 16, flush counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  ILEN  fetched instruction.
- in_pc  in  XLEN  PC of the fetched instruction.
- flush  in  1  synchronous pipeline flush (branch/jump redirect).
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  ILEN  instruction, or NOP_INSTR when invalid.
- out_pc  out  XLEN  PC, or 0 when invalid.
- out_pc_next  out  XLEN  captured in_pc+PC_STEP, or 0 when invalid.
- out_noflush  out  1  equals out_valid; 1 = genuine, non-bubble instruction.
- flush_cnt  out  CNT_W  saturating count of effective flushes.

Behaviour:
- Reset (async):
  - main and skid entries invalid.
  - out_valid=0, out_noflush=0, out_instr=NOP_INSTR, out_pc=0, out_pc_next=0, flush_cnt=0.
  - in_ready=1 once reset deasserts (SKID=1); in_ready=1 during reset also permitted.
- Handshakes:
  - Input transfer: in_valid & in_ready at a clk edge.
  - Output transfer: out_valid & out_ready at a clk edge.
  - Latency: input accepted at edge N appears on out_* after edge N (1 cycle).
- pc_next:
  - Computed at capture as in_pc + PC_STEP, truncated to XLEN bits.
  - Example: 0xFFFF_FFFC wraps to 0x0000_0000.
- SKID=1 (registered path):
  - in_ready = !skid_valid, driven from a flop.
  - Main entry empty or draining (output transfer): main loads from skid if skid_valid, else from the input transfer. Skid then captures the input if the input was not used by main.
  - Main full and not draining: an input transfer goes to skid.
  - Order preserved: skid data always reaches main before any newer input.
  - Never more than 2 entries held. While skid_valid, no input is accepted.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - Skid logic absent; out_* otherwise identical.
- Flush (priority over all handshakes):
  - At the edge where flush=1, main and skid become invalid and payload forces to NOP_INSTR/0/0.
  - An input transfer in the same cycle is consumed and discarded.
  - An output transfer in the same cycle still completes (decode saw it).
  - In the next cycle out_valid=0 and in_ready=1.
- flush_cnt:
  - Increments by 1 at an edge where flush=1 and (main_valid | skid_valid | input transfer).
  - Holds at all-ones.
  - Flush of an already empty stage does not count.
- Invalid entry: out_instr/out_pc/out_pc_next hold bubble values, not stale data.
- Reset mid-operation: all entries drop immediately, asynchronously. No data survives.

Test Plan:
- Streaming: in_valid=1, out_ready=1, pc=0x100,0x104,0x108 → out_pc one cycle later, out_pc_next=0x104,0x108,0x10C, in_ready stays 1, no bubbles.
- Backpressure: main holds 0x200; out_ready=0 while 0x204 arrives → skid holds 0x204, in_ready=0 next cycle. Raise out_ready → out shows 0x200, then 0x204, then in_ready=1. No loss, no reorder.
- Flush with full skid: main=0x300, skid=0x304, flush=1 with in_valid(0x308) → next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1, 0x308 dropped, flush_cnt=1.
- Idle flush and saturation: flush on empty stage → flush_cnt unchanged. CNT_W=2 with 5 effective flushes → flush_cnt=3.
- Wrap and reset: in_pc=0xFFFF_FFFC → out_pc_next=0. Assert reset while full → out_valid=0 immediately, without waiting for a clk edge.
- SKID=0 build: out_ready=0 with main full → in_ready=0 combinationally in the same cycle. Streaming case gives identical out_* sequence to the SKID=1 build.
